// File: rtl/key_evt_pkg.sv
// Shared types and defaults for the key event arbiter.
package key_evt_pkg;

  localparam int NKEYS_DEF = 4;
  localparam int IDW_DEF   = $clog2(NKEYS_DEF);

  typedef struct packed {
    logic [IDW_DEF-1:0] id;
    logic               press;
  } evt_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  // Slot 2k is the press of channel k, slot 2k+1 its release.
  function automatic logic slot_is_press(input logic slot_lsb);
    return ~slot_lsb;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted slot and wraps.
module rr_arbiter #(
  parameter int N = 8,
  localparam int IW = $clog2(N)
) (
  input  logic          clk50m,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          adv,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [IW-1:0] slot_s;

  // Scan the N slots in priority order starting at ptr_q+1.
  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    slot_s  = '0;
    for (int i = 1; i <= N; i++) begin
      slot_s = IW'((int'(ptr_q) + i) % N);
      if (!any && req[slot_s]) begin
        any     = 1'b1;
        gnt_idx = slot_s;
      end else begin
        any     = any;
      end
    end
  end

  // One-hot form of the winner, used by the caller to retire the request.
  always_comb begin
    gnt_onehot = '0;
    if (any) begin
      gnt_onehot[gnt_idx] = 1'b1;
    end else begin
      gnt_onehot = '0;
    end
  end

  // Pointer follows the slot actually granted.
  always_comb begin
    if (adv && any) begin
      ptr_d = gnt_idx;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/key_event_arbiter.sv
// Queues press/release pulses from NKEYS channels onto one valid/ready event port.
// Release events are only tracked when KEY_RELEASE_EN is defined.
module key_event_arbiter
  import key_evt_pkg::*;
#(
  parameter int NKEYS = NKEYS_DEF,
  parameter int IDW   = $clog2(NKEYS)
) (
  input  logic             clk50m,
  input  logic             rst_n,
  input  logic [NKEYS-1:0] key_hi,
  input  logic [NKEYS-1:0] key_lo,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic [IDW-1:0]   evt_id,
  output logic             evt_press,
  output logic             ovf,
  input  logic             ovf_clr
);

  localparam int NS = 2 * NKEYS;
  localparam int SW = $clog2(NS);

  out_state_t      state_q, state_d;
  logic [NS-1:0]   req_q, req_d;
  logic [IDW-1:0]  evt_id_q, evt_id_d;
  logic            evt_press_q, evt_press_d;
  logic            ovf_q, ovf_d;

  logic [NS-1:0]   set_s;
  logic [NS-1:0]   req_eff_s;
  logic [NS-1:0]   gnt_onehot_s;
  logic [NS-1:0]   gnt_s;
  logic [SW-1:0]   gnt_idx_s;
  logic            any_s;
  logic            adv_s;
  logic            ovf_hit_s;

`ifndef KEY_RELEASE_EN
  logic            unused_key_lo_s;
  assign unused_key_lo_s = ^key_lo;
`endif

  // Map incoming pulses onto request slots.
  always_comb begin
    set_s = '0;
    for (int k = 0; k < NKEYS; k++) begin
      set_s[2*k] = key_hi[k];
`ifdef KEY_RELEASE_EN
      set_s[2*k+1] = key_lo[k];
`endif
    end
  end

  // Pulses arriving this cycle are visible to the arbiter, giving one-cycle latency.
  assign req_eff_s = req_q | set_s;
  assign adv_s     = any_s && ((state_q == EMPTY) || evt_ready);
  assign gnt_s     = adv_s ? gnt_onehot_s : '0;

  rr_arbiter #(
    .N (NS)
  ) u_rr (
    .clk50m     (clk50m),
    .rst_n      (rst_n),
    .req        (req_eff_s),
    .adv        (adv_s),
    .gnt_onehot (gnt_onehot_s),
    .gnt_idx    (gnt_idx_s),
    .any        (any_s)
  );

  // Pending set/clear and overflow detection.
  always_comb begin
    // A pulse on a slot whose new event is itself granted is consumed directly;
    // a pulse on a slot whose older event is granted stays pending.
    req_d     = (req_q & ~gnt_s) | (set_s & ~(gnt_s & ~req_q));
    ovf_hit_s = |(set_s & req_q & ~gnt_s);
    if (ovf_hit_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Output stage next-state: load on every grant, hold otherwise.
  always_comb begin
    state_d     = state_q;
    evt_id_d    = evt_id_q;
    evt_press_d = evt_press_q;
    case (state_q)
      EMPTY: begin
        if (adv_s) begin
          state_d = FULL;
        end else begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (evt_ready && !adv_s) begin
          state_d = EMPTY;
        end else begin
          state_d = FULL;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    if (adv_s) begin
      evt_id_d    = IDW'(gnt_idx_s >> 1);
      evt_press_d = slot_is_press(gnt_idx_s[0]);
    end else begin
      evt_id_d    = evt_id_q;
    end
  end

  // State, pending requests and registered outputs.
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      req_q       <= '0;
      evt_id_q    <= '0;
      evt_press_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      evt_id_q    <= evt_id_d;
      evt_press_q <= evt_press_d;
      ovf_q       <= ovf_d;
    end
  end

  assign evt_valid = (state_q == FULL);
  assign evt_id    = evt_id_q;
  assign evt_press = evt_press_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_key_event_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against an event-level model.
module tb_key_event_arbiter;

  localparam int NK = 4;
  localparam int NS = 2 * NK;

  logic          clk50m = 1'b0;
  logic          rst_n  = 1'b0;
  logic [NK-1:0] key_hi = '0;
  logic [NK-1:0] key_lo = '0;
  logic          evt_ready = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          evt_valid;
  logic [1:0]    evt_id;
  logic          evt_press;
  logic          ovf;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: set of pending events, last granted slot, presented event, overflow flag.
  bit m_pend [NS];
  int m_last;
  bit m_valid;
  int m_id;
  bit m_press;
  bit m_ovf;

  key_event_arbiter dut (
    .clk50m    (clk50m),
    .rst_n     (rst_n),
    .key_hi    (key_hi),
    .key_lo    (key_lo),
    .evt_ready (evt_ready),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .evt_press (evt_press),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #10 clk50m = ~clk50m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NS; s++) m_pend[s] = 1'b0;
    m_last  = 0;
    m_valid = 1'b0;
    m_id    = 0;
    m_press = 1'b0;
    m_ovf   = 1'b0;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    bit fresh [NS];
    int win;
    bit lost;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int k = 0; k < NK; k++) begin
      fresh[2*k] = key_hi[k];
`ifdef KEY_RELEASE_EN
      fresh[2*k+1] = key_lo[k];
`else
      fresh[2*k+1] = 1'b0;
`endif
    end
    win = -1;
    if (!m_valid || evt_ready) begin
      for (int i = 1; i <= NS; i++) begin
        int s;
        s = (m_last + i) % NS;
        if (win < 0 && (m_pend[s] || fresh[s])) win = s;
      end
    end
    lost = 1'b0;
    for (int s = 0; s < NS; s++) begin
      if (s == win) begin
        // The oldest event for this slot leaves; a fresh one only stays if an older one left.
        m_pend[s] = m_pend[s] && fresh[s];
      end else begin
        if (m_pend[s] && fresh[s]) lost = 1'b1;
        m_pend[s] = m_pend[s] || fresh[s];
      end
    end
    if (win >= 0) begin
      m_valid = 1'b1;
      m_id    = win / 2;
      m_press = (win % 2) == 0;
      m_last  = win;
    end else if (evt_ready) begin
      m_valid = 1'b0;
    end
    if (lost) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
  endtask

  // One clock: model sees the same edge inputs, then pulses are withdrawn.
  task automatic cyc();
    @(posedge clk50m);
    model_step();
    #1;
    key_hi  = '0;
    key_lo  = '0;
    ovf_clr = 1'b0;
  endtask

  // Continuous comparison against the model on the falling edge.
  always @(negedge clk50m) begin
    if (chk_en) begin
      chk("m_valid", 32'(evt_valid), 32'(m_valid));
      if (m_valid) begin
        chk("m_id", 32'(evt_id), 32'(m_id));
        chk("m_press", 32'(evt_press), 32'(m_press));
      end
      chk("m_ovf", 32'(ovf), 32'(m_ovf));
    end
  end

  initial begin
    model_reset();
    repeat (3) cyc();
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_id", 32'(evt_id), 32'd0);
    chk("rst_press", 32'(evt_press), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    evt_ready = 1'b1;
    cyc();

    // Single press: visible the cycle after the pulse, gone the cycle after that.
    key_hi = 4'b0100;
    cyc();
    chk("lat_valid", 32'(evt_valid), 32'd1);
    chk("lat_id", 32'(evt_id), 32'd2);
    chk("lat_press", 32'(evt_press), 32'd1);
    cyc();
    chk("lat_drop", 32'(evt_valid), 32'd0);

    // Park pointer on channel 3, then two full bursts come out as 0,1,2,3.
    key_hi = 4'b1000;
    cyc();
    chk("pre_id", 32'(evt_id), 32'd3);
    for (int b = 0; b < 2; b++) begin
      key_hi = 4'b1111;
      for (int n = 0; n < 4; n++) begin
        cyc();
        chk("burst_valid", 32'(evt_valid), 32'd1);
        chk("burst_id", 32'(evt_id), 32'(n));
      end
      if (b == 0) begin
        cyc();
        chk("burst_end", 32'(evt_valid), 32'd0);
      end
    end
    cyc();

    // Stall: held event stays put for ten cycles.
    evt_ready = 1'b0;
    key_hi = 4'b0010;
    cyc();
    for (int n = 0; n < 10; n++) begin
      cyc();
      chk("hold_id", 32'(evt_id), 32'd1);
      chk("hold_press", 32'(evt_press), 32'd1);
      chk("hold_ovf", 32'(ovf), 32'd0);
    end

    // Second press on an already pending channel 0 overflows; clear, then one delivery.
    key_hi = 4'b0001;
    cyc();
    chk("ovf_first", 32'(ovf), 32'd0);
    key_hi = 4'b0001;
    cyc();
    chk("ovf_set", 32'(ovf), 32'd1);
    ovf_clr = 1'b1;
    cyc();
    chk("ovf_clr", 32'(ovf), 32'd0);
    evt_ready = 1'b1;
    cyc();
    chk("ovf_deliver", 32'(evt_id), 32'd0);
    cyc();
    chk("ovf_once", 32'(evt_valid), 32'd0);

    // Press then release of channel 3.
    key_hi = 4'b1000;
    cyc();
    chk("rel_p_id", 32'(evt_id), 32'd3);
    chk("rel_p_press", 32'(evt_press), 32'd1);
    repeat (3) cyc();
    key_lo = 4'b1000;
    cyc();
`ifdef KEY_RELEASE_EN
    chk("rel_valid", 32'(evt_valid), 32'd1);
    chk("rel_id", 32'(evt_id), 32'd3);
    chk("rel_press", 32'(evt_press), 32'd0);
`else
    chk("rel_ignored", 32'(evt_valid), 32'd0);
`endif
    cyc();

    // Reset while an event is presented and more are pending.
    evt_ready = 1'b0;
    key_hi = 4'b0111;
    cyc();
    cyc();
    chk("mid_valid_pre", 32'(evt_valid), 32'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_valid", 32'(evt_valid), 32'd0);
    chk("mid_id", 32'(evt_id), 32'd0);
    chk("mid_press", 32'(evt_press), 32'd0);
    chk("mid_ovf", 32'(ovf), 32'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    evt_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      cyc();
      chk("post_rst_idle", 32'(evt_valid), 32'd0);
    end

    // Random traffic checked by the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      key_hi    = ($urandom_range(0, 3) == 0) ? NK'($urandom) : '0;
      key_lo    = ($urandom_range(0, 3) == 0) ? NK'($urandom) : '0;
      evt_ready = ($urandom_range(0, 2) != 0);
      ovf_clr   = ($urandom_range(0, 15) == 0);
      cyc();
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_event_arbiter.md
Name: key_event_arbiter

Overview:
- Collects one-cycle press pulses and release pulses from NKEYS independent debounced switch channels.
- Holds each event as a pending request and shares a single registered event output port between all channels.
- Uses round-robin arbitration and a valid/ready handshake on the output.
- Sits between the per-switch debouncers and the consumer logic (menu FSM, soft-CPU interface).

Parameters:
- NKEYS, 4, number of debounced switch channels (2..16).
- IDW, $clog2(NKEYS), width of the event key index.

Ports:
- clk50m  in  1  system clock, 50 MHz.
- rst_n  in  1  reset; asynchronous, active-low.
- key_hi  in  NKEYS  one-cycle press pulse per channel (debounced rising event).
- key_lo  in  NKEYS  one-cycle release pulse per channel (debounced falling event).
- evt_ready  in  1  consumer accepts the current event.
- evt_valid  out  1  event present on evt_id/evt_press.
- evt_id  out  IDW  channel index of the event.
- evt_press  out  1  1 = press, 0 = release.
- ovf  out  1  sticky overflow flag: an event was lost.
- ovf_clr  in  1  clears ovf (synchronous).

Behaviour:
- Reset values: evt_valid=0, evt_id=0, evt_press=0, ovf=0, all pending bits=0, RR pointer=0.
- Request vector req[2*NKEYS]:
  - req[2k] = pending press of channel k.
  - req[2k+1] = pending release of channel k.
- Pending set rules:
  - key_hi[k] sets req[2k].
  - key_lo[k] sets req[2k+1].
  - If the bit is already set and is not being granted in the same cycle, the event is dropped and ovf is set.
- Grant clears the granted bit. If a new pulse arrives on a granted bit in the same cycle, set wins and no overflow is raised.
- Output stage FSM, states EMPTY and FULL:
  - EMPTY: if any req is set, grant one, load evt_id/evt_press, go to FULL. Otherwise stay in EMPTY.
  - FULL: evt_valid=1; evt_id/evt_press held stable while evt_ready=0.
  - FULL with evt_ready=1: handshake completes. If another req is pending, grant and load it the same cycle (back-to-back, stay FULL); else go to EMPTY.
- Arbitration:
  - Round-robin over 2*NKEYS slots. Search starts at pointer+1 and wraps at 2*NKEYS-1 -> 0.
  - After each grant, pointer = granted slot.
- Latency: pulse at cycle t -> evt_valid=1 at t+1 at the earliest, when the output is EMPTY and no other req is pending.
- Throughput: one event per cycle while evt_ready=1.
- ovf:
  - Set has priority over ovf_clr in the same cycle.
  - ovf_clr with no new overflow clears ovf next cycle.
- Reset mid-handshake: all pending events are discarded; evt_valid drops asynchronously.
- key_hi and key_lo asserted on the same channel in the same cycle: both pending, ordered by round-robin.

Optional Feature:
- Macro: KEY_RELEASE_EN.
- Defined: release events behave as above.
- Undefined:
  - key_lo is ignored and release pending bits are constant 0.
  - The arbiter spans the press slots only, i.e. the 2k slots; odd slots are never requested.
  - evt_press is tied to 1 while evt_valid=1.
  - Port list is unchanged.

Decomposition:
- Package key_evt_pkg:
  - Default NKEYS constant.
  - Typedef evt_t {logic [IDW-1:0] id; logic press;}.
  - Enum out_state_t {EMPTY, FULL}.
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs req[N] and adv; outputs gnt_onehot, gnt_idx, any.
  - Internal pointer register advanced on adv.
  - Instantiated with N = 2*NKEYS.

Test Plan:
- Reset, then key_hi[2] pulse at cycle 5 with evt_ready=1 -> evt_valid=1 at cycle 6, evt_id=2, evt_press=1; evt_valid=0 at cycle 7.
- key_hi=4'b1111 in one cycle, evt_ready=1 -> ids 0,1,2,3 on four consecutive cycles; a second burst after that yields the same order (pointer wraps).
- evt_ready=0 held 10 cycles with key_hi[1] pending -> evt_id/evt_press stable throughout; ovf stays 0.
- evt_ready=0 and two key_hi[0] pulses while event 0 is already pending (not in output) -> ovf=1 one cycle after the second pulse; ovf_clr pulse -> ovf=0 next cycle; only one id=0 press is delivered.
- With KEY_RELEASE_EN: key_hi[3] then key_lo[3] four cycles later -> events (3,1) then (3,0). Without KEY_RELEASE_EN: only (3,1), with no second event.
- rst_n asserted while evt_valid=1 with three events pending -> all outputs 0 immediately; no event is delivered after release of reset.
